// File: rtl/spi1_cmd_target.sv
// SPI1 command target: receives mode-0 MSB-first frames from the MCU and turns them
// into bus write/read requests or CPU reset/ready updates; read data returns on MISO.
module spi1_cmd_target #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_sys_i,
  input  logic                  reset_ni,
  input  logic                  spi1_sck_i,
  input  logic                  spi1_cs_ni,
  input  logic                  spi1_mcu_tx_i,
  output logic                  spi1_mcu_rx_o,
  output logic                  spi1_mcu_rx_oe,
  output logic                  spi_ready_no,
  output logic                  bus_req_o,
  output logic                  bus_rw_no,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [7:0]            bus_data_o,
  input  logic [7:0]            bus_data_i,
  input  logic                  bus_done_i,
  output logic                  cpu_reset_o,
  output logic                  cpu_ready_o
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned MAX_BYTE = 4;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, tx_sync;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, tx_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic [BYTE_W-1:0]      shift_sr, miso_sr, rd_data;
  logic [CNT_W-1:0]       bit_cnt, byte_cnt;
  logic [BYTE_W-1:0]      frame [MAX_BYTE];
  logic                   is_write, is_read, is_set;

  // MISO is released the moment the MCU lets go of chip select.
  assign spi1_mcu_rx_oe = ~spi1_cs_ni;

  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      tx_sync  <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi1_sck_i};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi1_cs_ni};
      tx_sync  <= {tx_sync[SYNC_STAGES-2:0], spi1_mcu_tx_i};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign tx_s     = tx_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev & ~cs_s;
  assign cs_fall  = ~cs_s & cs_prev;
  assign cs_rise  = cs_s & ~cs_prev;

  // Bit/byte capture on MOSI and MISO serialisation of the last read result.
  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shift_sr      <= '0;
      miso_sr       <= '0;
      spi1_mcu_rx_o <= 1'b0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      for (int i = 0; i < int'(MAX_BYTE); i++) frame[i] <= '0;
    end else if (cs_fall) begin
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      miso_sr       <= rd_data;
      spi1_mcu_rx_o <= rd_data[BYTE_W-1];
    end else begin
      if (sck_rise) begin
        shift_sr <= {shift_sr[BYTE_W-2:0], tx_s};
        bit_cnt  <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_W'(BYTE_W - 1) && byte_cnt < CNT_W'(MAX_BYTE)) begin
          frame[byte_cnt[1:0]] <= {shift_sr[BYTE_W-2:0], tx_s};
          byte_cnt             <= byte_cnt + CNT_W'(1);
        end
      end
      if (sck_fall) begin
        miso_sr       <= {miso_sr[BYTE_W-2:0], 1'b0};
        spi1_mcu_rx_o <= miso_sr[BYTE_W-2];
      end
    end
  end

  // Only whole bytes count; byte_cnt never includes a trailing partial byte.
  assign is_write = (frame[0][7:1] == 7'b100_0000) && (byte_cnt >= CNT_W'(4));
  assign is_read  = (frame[0][7:1] == 7'b110_0000) && (byte_cnt >= CNT_W'(3));
  assign is_set   = (frame[0] == 8'h40) && (byte_cnt >= CNT_W'(2));

  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      bus_req_o    <= 1'b0;
      bus_rw_no    <= 1'b1;
      bus_addr_o   <= '0;
      bus_data_o   <= '0;
      spi_ready_no <= 1'b0;
      cpu_reset_o  <= 1'b1;
      cpu_ready_o  <= 1'b0;
      rd_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_rise) begin
            if (is_write || is_read) begin
              state        <= REQ;
              bus_req_o    <= 1'b1;
              spi_ready_no <= 1'b1;
              bus_rw_no    <= is_read;
              bus_addr_o   <= ADDR_WIDTH'({frame[0][0], frame[1], frame[2]});
              if (is_write) bus_data_o <= frame[3];
            end else if (is_set) begin
              cpu_reset_o <= frame[1][0];
              cpu_ready_o <= frame[1][1];
            end
          end
        end
        REQ: begin
          // Frames arriving here are shifted in but never decoded.
          if (bus_done_i) begin
            state        <= IDLE;
            bus_req_o    <= 1'b0;
            spi_ready_no <= 1'b0;
            if (bus_rw_no) rd_data <= bus_data_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi1_cmd_target.sv
// Directed bench for spi1_cmd_target: an MCU-side SPI driver with queued expectations
// for bus transactions and MISO bytes.
`timescale 1ns/1ps
module tb_spi1_cmd_target;

  localparam int HALF = 6;

  typedef struct packed {
    logic        rw;
    logic [16:0] addr;
    logic [7:0]  data;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        reset_ni, sck, cs_n, mosi;
  logic        miso, miso_oe, ready_n, bus_req, bus_rw_n;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_done, cpu_reset, cpu_ready;

  int checks = 0;
  int errors = 0;
  bus_exp_t   bus_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] rx_bytes [4];

  spi1_cmd_target #(.ADDR_WIDTH(17), .SYNC_STAGES(2)) dut (
    .clk_sys_i      (clk),
    .reset_ni       (reset_ni),
    .spi1_sck_i     (sck),
    .spi1_cs_ni     (cs_n),
    .spi1_mcu_tx_i  (mosi),
    .spi1_mcu_rx_o  (miso),
    .spi1_mcu_rx_oe (miso_oe),
    .spi_ready_no   (ready_n),
    .bus_req_o      (bus_req),
    .bus_rw_no      (bus_rw_n),
    .bus_addr_o     (bus_addr),
    .bus_data_o     (bus_wdata),
    .bus_data_i     (bus_rdata),
    .bus_done_i     (bus_done),
    .cpu_reset_o    (cpu_reset),
    .cpu_ready_o    (cpu_ready)
  );

  always #31 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      cycles(HALF);
      r[7-i] = miso;
      sck = 1'b1;
      cycles(HALF);
      sck = 1'b0;
    end
  endtask

  // data is left-aligned: first byte in [31:24]
  task automatic send_frame(input logic [31:0] data, input int nbytes, input int extra_bits);
    logic [7:0] b, r;
    cs_n = 1'b0;
    cycles(8);
    for (int k = 0; k < nbytes; k++) begin
      b = data[31-8*k -: 8];
      spi_bits(b, 8, r);
      rx_bytes[k] = r;
    end
    if (extra_bits > 0) begin
      b = data[31-8*nbytes -: 8];
      spi_bits(b, extra_bits, r);
    end
    cycles(HALF);
    cs_n = 1'b1;
    cycles(8);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus_req), 32'd1);
  endtask

  task automatic check_bus(input string tag);
    bus_exp_t e;
    e = bus_q.pop_front();
    check({tag, "_rw"}, 32'(bus_rw_n), 32'(e.rw));
    check({tag, "_addr"}, 32'(bus_addr), 32'(e.addr));
    check({tag, "_ready"}, 32'(ready_n), 32'd1);
    if (!e.rw) check({tag, "_data"}, 32'(bus_wdata), 32'(e.data));
  endtask

  task automatic done_pulse(input logic [7:0] d, input string tag);
    bus_rdata = d;
    bus_done  = 1'b1;
    @(negedge clk);
    bus_done  = 1'b0;
    bus_rdata = '0;
    check({tag, "_req_drop"}, 32'(bus_req), 32'd0);
    check({tag, "_ready_drop"}, 32'(ready_n), 32'd0);
  endtask

  task automatic check_miso(input string tag, input int n);
    for (int k = 0; k < n; k++) check(tag, 32'(rx_bytes[k]), 32'(miso_q.pop_front()));
  endtask

  initial begin
    reset_ni = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    bus_done = 1'b0; bus_rdata = '0;
    cycles(4);
    reset_ni = 1'b1;
    cycles(2);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_ready_n", 32'(ready_n), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_rw_n", 32'(bus_rw_n), 32'd1);
    check("rst_addr", 32'(bus_addr), 32'd0);
    check("rst_rx_oe", 32'(miso_oe), 32'd0);
    cs_n = 1'b0;
    #1;
    check("cs_low_rx_oe", 32'(miso_oe), 32'd1);
    cycles(6);
    cs_n = 1'b1;
    #1;
    check("cs_high_rx_oe", 32'(miso_oe), 32'd0);
    cycles(6);

    // SET_CPU: release CPU from reset and mark ready
    send_frame(32'h4002_0000, 2, 0);
    check("setcpu_reset", 32'(cpu_reset), 32'd0);
    check("setcpu_ready", 32'(cpu_ready), 32'd1);
    check("setcpu_no_req", 32'(bus_req), 32'd0);
    check("setcpu_ready_n", 32'(ready_n), 32'd0);

    // WRITE to upper bank
    bus_q.push_back('{rw: 1'b0, addr: 17'h18000, data: 8'h5A});
    send_frame(32'h8180_005A, 4, 0);
    wait_req("wr1_req");
    check_bus("wr1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wr1_hold", {bus_req, ready_n, bus_rw_n, bus_addr, bus_wdata},
            {1'b1, 1'b1, 1'b0, 17'h18000, 8'h5A});
    end
    done_pulse(8'h00, "wr1");

    // READ, then read data shifted back on MISO followed by zeros
    bus_q.push_back('{rw: 1'b1, addr: 17'h01234, data: 8'h00});
    send_frame(32'hC012_3400, 3, 0);
    wait_req("rd1_req");
    check_bus("rd1");
    done_pulse(8'hA5, "rd1");
    miso_q.push_back(8'hA5);
    miso_q.push_back(8'h00);
    send_frame(32'h0000_0000, 2, 0);
    check_miso("rd1_miso", 2);

    // Truncated WRITE frames produce no request
    send_frame(32'h8180_0000, 1, 4);
    check("trunc1_no_req", 32'(bus_req), 32'd0);
    check("trunc1_ready_n", 32'(ready_n), 32'd0);
    send_frame(32'h8180_0077, 3, 4);
    check("trunc2_no_req", 32'(bus_req), 32'd0);
    check("trunc2_ready_n", 32'(ready_n), 32'd0);

    // Frames during REQ are discarded; MISO still shows rd_data
    bus_q.push_back('{rw: 1'b0, addr: 17'h01122, data: 8'h33});
    send_frame(32'h8011_2233, 4, 0);
    wait_req("wr2_req");
    check_bus("wr2");
    miso_q.push_back(8'hA5);
    send_frame(32'h81FF_FF77, 4, 0);
    check_miso("busy_miso", 1);
    check("busy_addr", 32'(bus_addr), 32'h01122);
    check("busy_data", 32'(bus_wdata), 32'h33);
    send_frame(32'h4001_0000, 2, 0);
    check("busy_setcpu_reset", 32'(cpu_reset), 32'd0);
    check("busy_setcpu_ready", 32'(cpu_ready), 32'd1);
    done_pulse(8'hEE, "wr2");
    miso_q.push_back(8'hA5);
    send_frame(32'h0000_0000, 1, 0);
    check_miso("persist_miso", 1);

    // Reset while a request is pending
    bus_q.push_back('{rw: 1'b0, addr: 17'h00010, data: 8'hC3});
    send_frame(32'h8000_10C3, 4, 0);
    wait_req("wr3_req");
    check_bus("wr3");
    reset_ni = 1'b0;
    #1;
    check("midrst_req", 32'(bus_req), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_cpu_ready", 32'(cpu_ready), 32'd0);
    cycles(3);
    reset_ni = 1'b1;
    cycles(3);
    check("postrst_req", 32'(bus_req), 32'd0);

    bus_q.push_back('{rw: 1'b0, addr: 17'h10001, data: 8'h99});
    send_frame(32'h8100_0199, 4, 0);
    wait_req("wr4_req");
    check_bus("wr4");
    done_pulse(8'h00, "wr4");

    // bus_done in IDLE must not disturb anything
    bus_done = 1'b1;
    @(negedge clk);
    bus_done = 1'b0;
    cycles(2);
    check("idle_done_req", 32'(bus_req), 32'd0);
    check("idle_done_ready_n", 32'(ready_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
